comb_dbus_dmem_arbiter: RTL and testbench

// Shared data memory (0x10000000 region) for all harts, behind a combinational
// per-cycle arbiter. One single-ported 32-bit word RAM serves NCORES core request

---
 rtl/comb_dbus_dmem_arbiter.sv | 151 +++++++++++++++
 tb/tb_comb_dbus_dmem_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/comb_dbus_dmem_arbiter.sv
// Shared data memory for all harts behind a combinational round-robin arbiter.
// One single-ported 32-bit word RAM serves NCORES request ports. Cores that lose
// arbitration see stall in the same cycle. LR/SC reservations are tracked per core.
//
// Handshake: a core raises re/we with addr/wdata/wstrb/lr/sc and must keep all of
// them stable while its stall bit is high. A cycle where req=1 and stall=0 is the
// accepting cycle. The access takes effect at that cycle's rising edge. For a read
// or SC, the rdata slice is valid from the following cycle until that core's next
// read or SC is accepted.
module comb_dbus_dmem_arbiter #(
  parameter int NCORES     = 2,
  parameter int DMEM_ADDRW = 12
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [NCORES-1:0]            re_packed_i,
  input  logic [NCORES-1:0]            we_packed_i,
  input  logic [DMEM_ADDRW*NCORES-1:0] addr_packed_i,
  input  logic [32*NCORES-1:0]         wdata_packed_i,
  input  logic [4*NCORES-1:0]          wstrb_packed_i,
  input  logic [NCORES-1:0]            is_lr_packed_i,
  input  logic [NCORES-1:0]            is_sc_packed_i,
  output logic [32*NCORES-1:0]         rdata_packed_o,
  output logic [NCORES-1:0]            stall_packed_o
);

  localparam int LGW   = (NCORES > 1) ? $clog2(NCORES) : 1;
  localparam int DEPTH = 1 << DMEM_ADDRW;

  // Storage and architectural state
  logic [31:0]                        r_mem [DEPTH];
  logic [NCORES-1:0][31:0]            r_rdata;
  logic [NCORES-1:0]                  r_res_valid;
  logic [NCORES-1:0][DMEM_ADDRW-1:0]  r_res_addr;
  logic [LGW-1:0]                     r_last_grant;

  // Unpacked per-core views of the packed buses
  logic [NCORES-1:0][DMEM_ADDRW-1:0]  w_addr;
  logic [NCORES-1:0][31:0]            w_wdata;
  logic [NCORES-1:0][3:0]             w_wstrb;

  // Arbitration
  logic [NCORES-1:0]                  w_req;
  logic [NCORES-1:0]                  w_grant;
  logic [NCORES-1:0][LGW-1:0]         w_cand;
  logic                               w_any_grant;
  logic [LGW-1:0]                     w_gnt_idx;

  // Granted request, decoded
  logic [DMEM_ADDRW-1:0]              w_sel_addr;
  logic [31:0]                        w_sel_wdata;
  logic [3:0]                         w_sel_wstrb;
  logic                               w_rd;
  logic                               w_wr;
  logic                               w_lr;
  logic                               w_sc;
  logic                               w_sc_ok;
  logic                               w_do_write;

  assign w_addr  = addr_packed_i;
  assign w_wdata = wdata_packed_i;
  assign w_wstrb = wstrb_packed_i;

  // re together with we counts as a write
  assign w_req = re_packed_i | we_packed_i;

  // Search order: candidate k is (last_grant + 1 + k) mod NCORES
  for (genvar k = 0; k < NCORES; k++) begin : g_cand
    assign w_cand[k] = LGW'((int'(r_last_grant) + k + 1) % NCORES);
  end

  // Pick the first requesting core in round-robin order; nothing granted in reset
  always_comb begin
    w_any_grant = 1'b0;
    w_gnt_idx   = '0;
    w_grant     = '0;
    if (rst_ni) begin
      for (int k = 0; k < NCORES; k++) begin
        if (!w_any_grant && w_req[w_cand[k]]) begin
          w_any_grant = 1'b1;
          w_gnt_idx   = w_cand[k];
        end
      end
    end
    if (w_any_grant) begin
      w_grant[w_gnt_idx] = 1'b1;
    end
  end

  assign stall_packed_o = w_req & ~w_grant;

  assign w_sel_addr  = w_addr[w_gnt_idx];
  assign w_sel_wdata = w_wdata[w_gnt_idx];
  assign w_sel_wstrb = w_wstrb[w_gnt_idx];

  assign w_wr       = w_any_grant & we_packed_i[w_gnt_idx];
  assign w_rd       = w_any_grant & re_packed_i[w_gnt_idx] & ~we_packed_i[w_gnt_idx];
  assign w_lr       = w_rd & is_lr_packed_i[w_gnt_idx];
  assign w_sc       = w_wr & is_sc_packed_i[w_gnt_idx];
  assign w_sc_ok    = r_res_valid[w_gnt_idx] & (r_res_addr[w_gnt_idx] == w_sel_addr);
  assign w_do_write = w_wr & (~is_sc_packed_i[w_gnt_idx] | w_sc_ok);

  // Byte-masked RAM write; contents are not reset
  always_ff @(posedge clk_i) begin
    if (w_do_write) begin
      for (int b = 0; b < 4; b++) begin
        if (w_sel_wstrb[b]) begin
          r_mem[w_sel_addr][8*b +: 8] <= w_sel_wdata[8*b +: 8];
        end
      end
    end
  end

  // Grant pointer, per-core read data and LR/SC reservations
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_last_grant <= LGW'(NCORES - 1);
      r_res_valid  <= '0;
      r_res_addr   <= '0;
      r_rdata      <= '0;
    end else begin
      if (w_any_grant) begin
        r_last_grant <= w_gnt_idx;
      end
      if (w_rd) begin
        r_rdata[w_gnt_idx] <= r_mem[w_sel_addr];
      end
      if (w_sc) begin
        r_rdata[w_gnt_idx] <= {31'd0, ~w_sc_ok};
      end
      // A performed write kills other cores' reservations on the same word
      if (w_do_write) begin
        for (int j = 0; j < NCORES; j++) begin
          if ((LGW'(j) != w_gnt_idx) && (r_res_addr[j] == w_sel_addr)) begin
            r_res_valid[j] <= 1'b0;
          end
        end
      end
      if (w_lr) begin
        r_res_valid[w_gnt_idx] <= 1'b1;
        r_res_addr[w_gnt_idx]  <= w_sel_addr;
      end
      if (w_sc) begin
        r_res_valid[w_gnt_idx] <= 1'b0;
      end
    end
  end

  assign rdata_packed_o = r_rdata;

endmodule

// File: tb/tb_comb_dbus_dmem_arbiter.sv
// Bench for comb_dbus_dmem_arbiter: directed scenarios followed by random traffic,
// checked against a word-level memory/reservation model with an expected queue.
module tb_comb_dbus_dmem_arbiter;

  localparam int NC = 2;
  localparam int AW = 12;
  localparam int K_RD = 0;
  localparam int K_WR = 1;
  localparam int K_LR = 2;
  localparam int K_SC = 3;

  logic              clk;
  logic              rst_ni;
  logic [NC-1:0]     re_p;
  logic [NC-1:0]     we_p;
  logic [NC-1:0]     lr_p;
  logic [NC-1:0]     sc_p;
  logic [AW*NC-1:0]  addr_p;
  logic [32*NC-1:0]  wdata_p;
  logic [4*NC-1:0]   strb_p;
  logic [32*NC-1:0]  rdata_p;
  logic [NC-1:0]     stall_p;

  comb_dbus_dmem_arbiter #(.NCORES(NC), .DMEM_ADDRW(AW)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_ni),
    .re_packed_i    (re_p),
    .we_packed_i    (we_p),
    .addr_packed_i  (addr_p),
    .wdata_packed_i (wdata_p),
    .wstrb_packed_i (strb_p),
    .is_lr_packed_i (lr_p),
    .is_sc_packed_i (sc_p),
    .rdata_packed_o (rdata_p),
    .stall_packed_o (stall_p)
  );

  typedef struct {
    bit            v;
    int            kind;
    logic [AW-1:0] a;
    logic [31:0]   d;
    logic [3:0]    s;
  } op_t;

  op_t           pend[NC];
  logic [31:0]   m_mem [int];
  bit            m_res_v[NC];
  logic [AW-1:0] m_res_a[NC];
  int            m_last;
  logic [AW-1:0] last_lr[NC];

  logic [31:0]   exp_q[NC][$];
  logic [NC-1:0] stall_q[$];
  bit            rd_pend[NC];
  int            n_vec;
  int            n_err;

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] mem_rd(input int a);
    return m_mem.exists(a) ? m_mem[a] : 32'h0;
  endfunction

  function automatic void mem_wr(input int g, input logic [AW-1:0] a,
                                 input logic [31:0] d, input logic [3:0] s);
    logic [31:0] cur;
    cur = mem_rd(int'(a));
    for (int b = 0; b < 4; b++) begin
      if (s[b]) cur[8*b +: 8] = d[8*b +: 8];
    end
    m_mem[int'(a)] = cur;
    for (int j = 0; j < NC; j++) begin
      if (j != g && m_res_a[j] == a) m_res_v[j] = 1'b0;
    end
  endfunction

  function automatic void apply(input int g);
    bit ok;
    case (pend[g].kind)
      K_RD: exp_q[g].push_back(mem_rd(int'(pend[g].a)));
      K_LR: begin
        exp_q[g].push_back(mem_rd(int'(pend[g].a)));
        m_res_v[g] = 1'b1;
        m_res_a[g] = pend[g].a;
      end
      K_WR: mem_wr(g, pend[g].a, pend[g].d, pend[g].s);
      default: begin
        ok = m_res_v[g] && (m_res_a[g] == pend[g].a);
        if (ok) mem_wr(g, pend[g].a, pend[g].d, pend[g].s);
        exp_q[g].push_back(ok ? 32'd0 : 32'd1);
        m_res_v[g] = 1'b0;
      end
    endcase
  endfunction

  function automatic bit any_pend();
    bit r = 1'b0;
    for (int c = 0; c < NC; c++) r |= pending_of(c);
    return r;
  endfunction

  function automatic bit pending_of(input int c);
    return pend[c].v;
  endfunction

  // ---------------- driver tasks ----------------
  // One clock: drive every core's held request, let the model pick the winner.
  task automatic cycle(input bit rst_val);
    logic [NC-1:0] es;
    int g;
    @(posedge clk);
    #1;
    rst_ni = rst_val;
    re_p = '0; we_p = '0; lr_p = '0; sc_p = '0;
    addr_p = '0; wdata_p = '0; strb_p = '0;
    for (int c = 0; c < NC; c++) begin
      if (pend[c].v) begin
        re_p[c] = (pend[c].kind == K_RD) || (pend[c].kind == K_LR);
        we_p[c] = (pend[c].kind == K_WR) || (pend[c].kind == K_SC);
        lr_p[c] = (pend[c].kind == K_LR);
        sc_p[c] = (pend[c].kind == K_SC);
        addr_p[c*AW +: AW]  = pend[c].a;
        wdata_p[c*32 +: 32] = pend[c].d;
        strb_p[c*4 +: 4]    = pend[c].s;
      end
    end
    g = -1;
    if (!rst_val) begin
      m_last = NC - 1;
      for (int c = 0; c < NC; c++) m_res_v[c] = 1'b0;
    end else begin
      for (int k = 1; k <= NC; k++) begin
        if (g < 0 && pend[(m_last + k) % NC].v) g = (m_last + k) % NC;
      end
    end
    es = re_p | we_p;
    if (g >= 0) es[g] = 1'b0;
    stall_q.push_back(es);
    if (g >= 0) begin
      apply(g);
      pend[g].v = 1'b0;
      m_last = g;
    end
  endtask

  task automatic issue(input int c, input int kind, input int a,
                       input logic [31:0] d, input logic [3:0] s);
    pend[c].v    = 1'b1;
    pend[c].kind = kind;
    pend[c].a    = AW'(a);
    pend[c].d    = d;
    pend[c].s    = s;
  endtask

  task automatic run_idle();
    int n = 0;
    while (any_pend() && n < 50) begin
      cycle(1'b1);
      n++;
    end
    if (any_pend()) begin
      n_vec++;
      n_err++;
      $display("FAIL drain_timeout: got pending after %0d cycles expected none", n);
      for (int c = 0; c < NC; c++) pend[c].v = 1'b0;
    end
  endtask

  task automatic op(input int c, input int kind, input int a,
                    input logic [31:0] d, input logic [3:0] s);
    issue(c, kind, a, d, s);
    run_idle();
  endtask

  // Leaves rst_ni low; the next cycle(1) releases it.
  task automatic do_reset(input int n);
    cycle(1'b1);
    for (int i = 0; i < n; i++) cycle(1'b0);
    #1;
    for (int c = 0; c < NC; c++) check($sformatf("rst_rdata%0d", c), rdata_p[32*c +: 32], 32'h0);
  endtask

  task automatic rand_issue(input int c);
    int kind;
    int a;
    kind = int'($urandom_range(0, 3));
    a = 'h40 + int'($urandom_range(0, 15));
    if (kind == K_SC && $urandom_range(0, 1) == 1) a = int'(last_lr[c]);
    if (kind == K_LR) last_lr[c] = AW'(a);
    issue(c, kind, a, $urandom, 4'($urandom_range(0, 15)));
  endtask

  // ---------------- scoreboard monitor ----------------
  initial begin
    for (int c = 0; c < NC; c++) rd_pend[c] = 1'b0;
    forever begin
      @(negedge clk);
      if (stall_q.size() > 0) begin
        logic [NC-1:0] es;
        es = stall_q.pop_front();
        check("stall", 32'(stall_p), 32'(es));
      end
      for (int c = 0; c < NC; c++) begin
        if (rd_pend[c]) begin
          if (exp_q[c].size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL rdata%0d: got %h expected no response", c, rdata_p[32*c +: 32]);
          end else begin
            check($sformatf("rdata%0d", c), rdata_p[32*c +: 32], exp_q[c].pop_front());
          end
        end
        rd_pend[c] = rst_ni && !stall_p[c] &&
                     ((re_p[c] && !we_p[c]) || (we_p[c] && sc_p[c]));
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    n_vec = 0;
    n_err = 0;
    rst_ni = 1'b0;
    re_p = '0; we_p = '0; lr_p = '0; sc_p = '0;
    addr_p = '0; wdata_p = '0; strb_p = '0;
    m_last = NC - 1;
    for (int c = 0; c < NC; c++) begin
      pend[c].v = 1'b0;
      m_res_v[c] = 1'b0;
      m_res_a[c] = '0;
      last_lr[c] = AW'('h40);
    end

    cycle(1'b0);
    cycle(1'b0);
    #1;
    for (int c = 0; c < NC; c++) check($sformatf("init_rdata%0d", c), rdata_p[32*c +: 32], 32'h0);

    // write then read back on core 0
    op(0, K_WR, 'h10, 32'hDEADBEEF, 4'hF);
    op(0, K_RD, 'h10, 32'h0, 4'h0);

    // simultaneous reads, winner alternates
    for (int r = 0; r < 4; r++) begin
      issue(0, K_RD, 'h10, 32'h0, 4'h0);
      issue(1, K_RD, 'h10, 32'h0, 4'h0);
      run_idle();
    end

    // byte strobes
    op(1, K_WR, 'h11, 32'h11223344, 4'hF);
    op(1, K_WR, 'h11, 32'hAABBCCDD, 4'b0010);
    op(0, K_RD, 'h11, 32'h0, 4'h0);

    // LR/SC success then repeated SC failure
    op(0, K_WR, 'h20, 32'h0, 4'hF);
    op(0, K_LR, 'h20, 32'h0, 4'h0);
    op(0, K_SC, 'h20, 32'h5, 4'hF);
    op(0, K_RD, 'h20, 32'h0, 4'h0);
    op(0, K_SC, 'h20, 32'h9, 4'hF);
    op(0, K_RD, 'h20, 32'h0, 4'h0);

    // another core's write to the reserved word breaks the reservation
    op(0, K_LR, 'h20, 32'h0, 4'h0);
    op(1, K_WR, 'h20, 32'h77, 4'hF);
    op(0, K_SC, 'h20, 32'h66, 4'hF);
    op(0, K_RD, 'h20, 32'h0, 4'h0);
    // a write to a neighbouring word does not
    op(1, K_WR, 'h21, 32'h88, 4'hF);
    op(0, K_LR, 'h20, 32'h0, 4'h0);
    op(1, K_WR, 'h21, 32'h99, 4'hF);
    op(0, K_SC, 'h20, 32'h1234, 4'hF);
    op(0, K_RD, 'h20, 32'h0, 4'h0);

    // reset between LR and SC
    op(0, K_LR, 'h20, 32'h0, 4'h0);
    do_reset(2);
    op(0, K_SC, 'h20, 32'h4321, 4'hF);
    op(1, K_RD, 'h20, 32'h0, 4'h0);

    // request held across reset deassert: stalled in reset, accepted first cycle out
    do_reset(1);
    issue(0, K_WR, 'h30, 32'hCAFE0001, 4'hF);
    cycle(1'b0);
    run_idle();
    op(1, K_RD, 'h30, 32'h0, 4'h0);

    // random traffic on a small window
    for (int a = 'h40; a < 'h50; a++) op(a % NC, K_WR, a, $urandom, 4'hF);
    for (int t = 0; t < 600; t++) begin
      for (int c = 0; c < NC; c++) begin
        if (!pend[c].v && $urandom_range(0, 9) < 6) rand_issue(c);
      end
      cycle(1'b1);
    end
    run_idle();

    cycle(1'b1);
    cycle(1'b1);
    cycle(1'b1);
    for (int c = 0; c < NC; c++) check($sformatf("leftover%0d", c), 32'(exp_q[c].size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
